pdm_sample_feeder: RTL and testbench

Upstream stage of the `pdm` modulator. It accepts signed 8-bit audio samples over a valid/ready handshake and buffers them in a small FIFO. It generates the modulator's `tick_in` strobe at the PDM rate and presents one level per sample period on `level_out`. That level is either held or linearly interpolated. `level_out` and `tick_out` connect directly to `pdm.level_in` and `pdm.tick_in`.

---
 rtl/pdm_pkg.sv | 15 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/pdm_sample_feeder.sv | 103 ++++++++++
 tb/tb_pdm_sample_feeder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: level and step types shared by the pdm sample path.
package pdm_pkg;

    localparam int PDM_LEVEL_W = 8;

    typedef logic signed [PDM_LEVEL_W-1:0] pdm_level_t;
    typedef logic signed [PDM_LEVEL_W:0]   pdm_step_t;

    // Exact difference of two levels; one extra bit avoids overflow.
    function automatic pdm_step_t pdm_diff(input pdm_level_t a,
                                           input pdm_level_t b);
        return {a[PDM_LEVEL_W-1], a} - {b[PDM_LEVEL_W-1], b};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO of signed levels with occupancy count.
// Push when full and pop when empty are ignored.
module sample_fifo
    import pdm_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  pdm_level_t    wr_data,
    output pdm_level_t    rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    pdm_level_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pdm_sample_feeder.sv
// pdm_sample_feeder: buffers samples, strobes pdm ticks, presents one level
// per sample period. PDM_INTERP_EN selects linear interpolation over hold.
module pdm_sample_feeder
    import pdm_pkg::*;
#(
    parameter  int TICK_DIV   = 4,
    parameter  int LOG2_OSR   = 6,
    parameter  int FIFO_DEPTH = 16,
    localparam int DW         = $clog2(TICK_DIV),
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  pdm_level_t    sample_in,
    input  logic          sample_valid_in,
    output logic          sample_ready_out,
    output pdm_level_t    level_out,
    output logic          tick_out,
    output logic          underflow_out,
    output logic [CW-1:0] fifo_count_out
);

    logic [DW-1:0]       div_cnt;
    logic [LOG2_OSR-1:0] phase;
    logic                full;
    logic                empty;
    logic                push;
    logic                boundary;
    logic                div_wrap;
    pdm_level_t          head;
    pdm_level_t          target;

    assign sample_ready_out = !rst_in && !full;
    assign push     = sample_valid_in && sample_ready_out;
    assign boundary = tick_out && (&phase);
    assign div_wrap = (div_cnt == DW'(TICK_DIV - 1));
    // An empty FIFO at a boundary holds the present level.
    assign target   = empty ? level_out : head;

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .push    (push),
        .pop     (boundary),
        .wr_data (sample_in),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .count   (fifo_count_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt       <= '0;
            tick_out      <= 1'b0;
            phase         <= '0;
            underflow_out <= 1'b0;
        end else begin
            div_cnt       <= div_wrap ? '0 : div_cnt + DW'(1);
            tick_out      <= div_wrap;
            underflow_out <= boundary && empty;
            if (tick_out) phase <= phase + LOG2_OSR'(1);
        end
    end

`ifdef PDM_INTERP_EN
    localparam int ACC_W = PDM_LEVEL_W + LOG2_OSR;

    logic signed [ACC_W-1:0] acc;
    pdm_step_t               step;
    pdm_step_t               step_new;

    assign step_new  = pdm_diff(target, level_out);
    // Upper slice equals acc >>> LOG2_OSR truncated to a level.
    assign level_out = acc[ACC_W-1:LOG2_OSR];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc  <= '0;
            step <= '0;
        end else if (tick_out) begin
            if (boundary) begin
                step <= step_new;
                acc  <= acc + ACC_W'(step_new);
            end else begin
                acc  <= acc + ACC_W'(step);
            end
        end
    end
`else
    pdm_level_t level_q;

    assign level_out = level_q;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            level_q <= '0;
        else if (boundary)
            level_q <= target;
    end
`endif

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// tb_pdm_sample_feeder: random traffic against a sample-queue model of the
// feeder; the model follows PDM_INTERP_EN the same way the build does.
module tb_pdm_sample_feeder;

    localparam int TD    = 4;
    localparam int L2    = 2;
    localparam int OSR   = 4;
    localparam int DEPTH = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              sample_valid_in;
    logic              sample_ready_out;
    logic              tick_out;
    logic              underflow_out;
    logic signed [7:0] sample_in;
    logic signed [7:0] level_out;
    logic [2:0]        fifo_count_out;

    pdm_sample_feeder #(
        .TICK_DIV   (TD),
        .LOG2_OSR   (L2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .level_out        (level_out),
        .tick_out         (tick_out),
        .underflow_out    (underflow_out),
        .fifo_count_out   (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queued samples, cycles since reset, current segment.
    int q[$];
    int n_edge    = 0;
    int lvl       = 0;
    int seg_start = 0;
    int seg_tgt   = 0;
    int seg_j     = 0;
    bit under     = 0;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    function automatic bit is_tick(input int n);
        return n > 0 && n % TD == 0;
    endfunction

    function automatic int floor_div(input int a, input int b);
        int r;
        r = a / b;
        if (a % b != 0 && a < 0) r = r - 1;
        return r;
    endfunction

    task automatic cycle(input bit r, input bit v, input int d);
        bit tick_now;
        bit pushing;
        int tgt;
        rst_in          = r;
        sample_valid_in = v;
        sample_in       = 8'(d);
        #1;
        check("ready", sample_ready_out, !r && q.size() < DEPTH);
        pushing = v && !r && q.size() < DEPTH;
        @(posedge clk_in);
        if (r) begin
            q.delete();
            n_edge    = 0;
            lvl       = 0;
            seg_start = 0;
            seg_tgt   = 0;
            seg_j     = 0;
            under     = 0;
        end else begin
            tick_now = is_tick(n_edge);
            under    = 0;
            if (tick_now && (n_edge / TD) % OSR == 0) begin
                if (q.size() > 0) begin
                    tgt = q.pop_front();
                end else begin
                    tgt   = lvl;
                    under = 1;
                end
                seg_start = lvl;
                seg_tgt   = tgt;
                seg_j     = 0;
            end
            if (tick_now) begin
`ifdef PDM_INTERP_EN
                if (seg_j < OSR) seg_j++;
                lvl = floor_div(seg_start * OSR
                                + (seg_tgt - seg_start) * seg_j, OSR);
`else
                lvl = seg_tgt;
`endif
            end
            if (pushing) q.push_back(d);
            n_edge++;
        end
        #1;
        check("tick", tick_out, is_tick(n_edge));
        check("level", level_out, lvl);
        check("underflow", underflow_out, under);
        check("count", fifo_count_out, q.size());
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int mode;
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        @(posedge clk_in);
        #1;
        repeat (3) cycle(1, 0, 0);

        // Directed ramp: 100 then -128, then starve to see underflow hold.
        cycle(0, 1, 100);
        cycle(0, 1, -128);
        repeat (70) cycle(0, 0, 0);

        // Valid held high: fill to DEPTH, ready reopens after each pop.
        repeat (60) cycle(0, 1, rnd_sample());

        mode = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 64 == 0) mode = int'($urandom_range(0, 4));
            cycle($urandom_range(0, 499) == 0,
                  int'($urandom_range(0, 3)) < mode,
                  rnd_sample());
        end

        // Reset while samples are queued mid-stream.
        cycle(1, 0, 0);
        cycle(0, 1, 100);
        repeat (20) cycle(0, 0, 0);
        cycle(0, 1, 20);
        cycle(0, 1, -20);
        cycle(0, 1, 60);
        cycle(1, 1, 7);
        repeat (12) cycle(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
